// File: rtl/scan_config_ctrl_pkg.sv
// Shared definitions for the scan-chain configuration loader and readback logic.
package scan_config_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_SHIFT = 3'd2,
    ST_DONE  = 3'd3,
    ST_ERR   = 3'd4
  } state_t;

  // Width of a counter able to hold the value len itself.
  function automatic int cnt_width(input int len);
    return $clog2(len + 1);
  endfunction

endpackage

// File: rtl/scan_config_ctrl_shifter.sv
// Parallel-load right-shift word register with a count of bits still to emit.
module scan_config_ctrl_shifter #(
  parameter int WORD_WIDTH = 8,
  parameter int CNT_W      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  shift,
  input  logic [WORD_WIDTH-1:0] d,
  input  logic [CNT_W-1:0]      n,
  output logic                  q0,
  output logic                  empty
);

  logic [WORD_WIDTH-1:0] q;
  logic [CNT_W-1:0]      cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q   <= '0;
      cnt <= '0;
    end else if (load) begin
      q   <= d;
      cnt <= n;
    end else if (shift) begin
      q   <= q >> 1;
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign q0    = q[0];
  assign empty = (cnt == '0);

endmodule

// File: rtl/scan_config_ctrl.sv
// Streams host config words LSB-first onto the CLB/BLE scan chain, checks the
// bitstream length and folds the displaced chain contents into a parity bit.
module scan_config_ctrl
  import scan_config_ctrl_pkg::*;
#(
  parameter int CHAIN_LEN  = 168,
  parameter int WORD_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WORD_WIDTH-1:0] cfg_data,
  input  logic                  cfg_valid,
  input  logic                  cfg_last,
  output logic                  cfg_ready,
  output logic                  scan_en,
  output logic                  scan_out,
  input  logic                  scan_ret,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic                  old_parity
);

  localparam int CNT_W = cnt_width(CHAIN_LEN);
  localparam int SC_W  = cnt_width(WORD_WIDTH);

  state_t           state;
  logic [CNT_W-1:0] remaining;
  logic             accept, last_word, len_bad;
  logic             sh_load, sh_shift, sh_q0, sh_empty;
  logic [SC_W-1:0]  sh_n;

  assign cfg_ready = (state == ST_LOAD);
  assign accept    = cfg_valid & cfg_ready;
  assign last_word = (remaining <= CNT_W'(WORD_WIDTH));
  // Length is wrong whenever cfg_last disagrees with "this word reaches the end".
  assign len_bad   = last_word ^ cfg_last;
  assign sh_load   = accept & ~len_bad;
  assign sh_shift  = (state == ST_SHIFT) & ~sh_empty;

  // Bit 0 goes straight to scan_out on accept, so the shifter holds the rest.
  assign sh_n = last_word ? SC_W'(remaining - CNT_W'(1)) : SC_W'(WORD_WIDTH - 1);

  scan_config_ctrl_shifter #(
    .WORD_WIDTH (WORD_WIDTH),
    .CNT_W      (SC_W)
  ) u_shifter (
    .clk   (clk),
    .rst   (rst),
    .load  (sh_load),
    .shift (sh_shift),
    .d     (cfg_data >> 1),
    .n     (sh_n),
    .q0    (sh_q0),
    .empty (sh_empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      remaining  <= '0;
      scan_en    <= 1'b0;
      scan_out   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      old_parity <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE, ST_ERR: begin
          if (start) begin
            state      <= ST_LOAD;
            remaining  <= CNT_W'(CHAIN_LEN);
            busy       <= 1'b1;
            done       <= 1'b0;
            err        <= 1'b0;
            old_parity <= 1'b0;
          end
        end
        ST_LOAD: begin
          if (accept) begin
            if (len_bad) begin
              state <= ST_ERR;
              err   <= 1'b1;
              busy  <= 1'b0;
            end else begin
              state    <= ST_SHIFT;
              scan_en  <= 1'b1;
              scan_out <= cfg_data[0];
            end
          end
        end
        ST_SHIFT: begin
          // Every SHIFT cycle has scan_en high, so each one moves one chain bit.
          remaining  <= remaining - CNT_W'(1);
          old_parity <= old_parity ^ scan_ret;
          if (!sh_empty) begin
            scan_out <= sh_q0;
          end else begin
            scan_en  <= 1'b0;
            scan_out <= 1'b0;
            if (remaining == CNT_W'(1)) begin
              state <= ST_DONE;
              done  <= 1'b1;
              busy  <= 1'b0;
            end else begin
              state <= ST_LOAD;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_scan_config_ctrl.sv
// Directed bench: unit 0 has a 168-bit chain, unit 1 a 20-bit chain.
module tb_scan_config_ctrl;

  logic clk = 1'b0;
  logic rst;
  logic [1:0]      start, cfg_valid, cfg_last, scan_ret;
  logic [1:0][7:0] cfg_data;
  logic [1:0]      cfg_ready, scan_en, scan_out, busy, done, err, old_parity;

  int   vectors = 0;
  int   miscompares = 0;

  int   pulses [2];
  logic bits   [2][2048];
  logic exp_par[2];
  bit   rnd_ret = 1'b0;
  bit   ret_level = 1'b0;

  always #5 clk = ~clk;

  scan_config_ctrl #(.CHAIN_LEN(168), .WORD_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start[0]), .cfg_data(cfg_data[0]),
    .cfg_valid(cfg_valid[0]), .cfg_last(cfg_last[0]), .cfg_ready(cfg_ready[0]),
    .scan_en(scan_en[0]), .scan_out(scan_out[0]), .scan_ret(scan_ret[0]),
    .busy(busy[0]), .done(done[0]), .err(err[0]), .old_parity(old_parity[0])
  );

  scan_config_ctrl #(.CHAIN_LEN(20), .WORD_WIDTH(8)) dut20 (
    .clk(clk), .rst(rst), .start(start[1]), .cfg_data(cfg_data[1]),
    .cfg_valid(cfg_valid[1]), .cfg_last(cfg_last[1]), .cfg_ready(cfg_ready[1]),
    .scan_en(scan_en[1]), .scan_out(scan_out[1]), .scan_ret(scan_ret[1]),
    .busy(busy[1]), .done(done[1]), .err(err[1]), .old_parity(old_parity[1])
  );

  initial begin
    for (int u = 0; u < 2; u++) begin
      pulses[u]  = 0;
      exp_par[u] = 1'b0;
    end
  end

  // Chain model: drive scan_ret for the coming edge and log every shifted bit.
  always @(negedge clk) begin
    for (int u = 0; u < 2; u++) begin
      logic r;
      r = rnd_ret ? 1'($urandom_range(1, 0)) : ret_level;
      scan_ret[u] <= r;
      if (scan_en[u] === 1'b1) begin
        exp_par[u] <= exp_par[u] ^ r;
        if (pulses[u] < 2048) bits[u][pulses[u]] <= scan_out[u];
        pulses[u] <= pulses[u] + 1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start(input int u);
    start[u] = 1'b1;
    @(negedge clk);
    start[u] = 1'b0;
  endtask

  task automatic send_word(input int u, input logic [7:0] d, input logic l);
    int t = 0;
    cfg_data[u] = d; cfg_last[u] = l; cfg_valid[u] = 1'b1;
    while (cfg_ready[u] !== 1'b1 && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) chk("ready_timeout", 32'(t), 32'(0));
    @(negedge clk);
    cfg_valid[u] = 1'b0; cfg_last[u] = 1'b0;
  endtask

  task automatic send_stream(input int u, input int nwords, input logic [7:0] d,
                             input int last_at, input int gap);
    for (int i = 1; i <= nwords; i++) begin
      send_word(u, d, 1'(i == last_at));
      repeat (gap) @(negedge clk);
    end
  endtask

  task automatic wait_idle(input int u);
    int t = 0;
    while (busy[u] === 1'b1 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 2000) chk("idle_timeout", 32'(t), 32'(0));
  endtask

  initial begin
    int b, bad;
    logic p0;
    logic [7:0]  pat;
    logic [19:0] e2;
    start = '0; cfg_valid = '0; cfg_last = '0; cfg_data = '0;
    rst = 1'b0;
    #1 rst = 1'b1;
    #1;
    chk("reset_outs", 32'({cfg_ready[0], scan_en[0], scan_out[0], busy[0], done[0],
                           err[0], old_parity[0]}), 32'(0));
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // 1: nominal 21 x 0xA5
    b = pulses[0];
    pulse_start(0);
    chk("t1_busy", 32'(busy[0]), 32'(1));
    send_stream(0, 21, 8'hA5, 21, 0);
    wait_idle(0);
    chk("t1_pulses", 32'(pulses[0] - b), 32'(168));
    chk("t1_done", 32'(done[0]), 32'(1));
    chk("t1_err", 32'(err[0]), 32'(0));
    chk("t1_parity", 32'(old_parity[0]), 32'(0));
    pat = 8'hA5; bad = 0;
    for (int k = 0; k < 168; k++) if (bits[0][b + k] !== pat[k % 8]) bad++;
    chk("t1_pattern", 32'(bad), 32'(0));

    // 2: partial final word on the 20-bit chain
    b = pulses[1];
    pulse_start(1);
    send_word(1, 8'hFF, 1'b0);
    send_word(1, 8'h00, 1'b0);
    send_word(1, 8'h0F, 1'b1);
    wait_idle(1);
    chk("t2_pulses", 32'(pulses[1] - b), 32'(20));
    chk("t2_done", 32'(done[1]), 32'(1));
    e2 = 20'hF00FF; bad = 0;
    for (int k = 0; k < 20; k++) if (bits[1][b + k] !== e2[k]) bad++;
    chk("t2_pattern", 32'(bad), 32'(0));

    // 3: early last on word 5, then a good reload
    b = pulses[0];
    pulse_start(0);
    send_stream(0, 5, 8'h3C, 5, 0);
    wait_idle(0);
    repeat (3) @(negedge clk);
    chk("t3_err", 32'(err[0]), 32'(1));
    chk("t3_pulses", 32'(pulses[0] - b), 32'(32));
    chk("t3_busy", 32'(busy[0]), 32'(0));
    b = pulses[0];
    pulse_start(0);
    send_stream(0, 21, 8'h5A, 21, 0);
    wait_idle(0);
    chk("t3_redo", 32'({done[0], err[0]}), 32'(2));
    chk("t3_redo_pulses", 32'(pulses[0] - b), 32'(168));

    // 4: missing last
    b = pulses[0];
    pulse_start(0);
    send_stream(0, 21, 8'hC3, 0, 0);
    wait_idle(0);
    chk("t4_err", 32'({done[0], err[0]}), 32'(1));
    chk("t4_pulses", 32'(pulses[0] - b), 32'(160));

    // 5: valid gaps, random chain contents, start pulsed mid-shift
    rnd_ret = 1'b1;
    @(negedge clk);
    b = pulses[0]; p0 = exp_par[0];
    pulse_start(0);
    for (int i = 1; i <= 21; i++) begin
      send_word(0, 8'h96, 1'(i == 21));
      if (i == 10) pulse_start(0);
      repeat (3) @(negedge clk);
    end
    wait_idle(0);
    rnd_ret = 1'b0;
    chk("t5_done", 32'({done[0], err[0]}), 32'(2));
    chk("t5_pulses", 32'(pulses[0] - b), 32'(168));
    chk("t5_parity", 32'(old_parity[0]), 32'(exp_par[0] ^ p0));

    // 6: async reset mid-shift, then full reload with all-ones chain
    rnd_ret = 1'b1;
    pulse_start(0);
    send_word(0, 8'hA5, 1'b0);
    send_word(0, 8'hA5, 1'b0);
    rst = 1'b1;
    #1;
    chk("t6_rst_outs", 32'({cfg_ready[0], scan_en[0], scan_out[0], busy[0], done[0],
                            err[0], old_parity[0]}), 32'(0));
    @(negedge clk);
    rst = 1'b0;
    rnd_ret = 1'b0; ret_level = 1'b1;
    @(negedge clk);
    b = pulses[0];
    pulse_start(0);
    send_stream(0, 21, 8'hF0, 21, 0);
    wait_idle(0);
    chk("t6_done", 32'({done[0], err[0]}), 32'(2));
    chk("t6_pulses", 32'(pulses[0] - b), 32'(168));
    chk("t6_parity", 32'(old_parity[0]), 32'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
